// File: rtl/grid_actor_mover.sv
// grid_actor_mover: per-frame tile-grid movement engine for one maze actor.
// Buffers a requested turn and probes the shared map RAM for walls before each aligned step.
module grid_actor_mover #(
  parameter int         MAP_COLS  = 32,
  parameter int         MAP_ROWS  = 36,
  parameter int         TILE      = 8,
  parameter int         START_X   = 24,
  parameter int         START_Y   = 8,
  parameter logic [1:0] START_DIR = 2'd3,
  parameter int         XW        = $clog2(MAP_COLS * TILE),
  parameter int         YW        = $clog2(MAP_ROWS * TILE),
  parameter int         AW        = $clog2(MAP_COLS * MAP_ROWS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_tick,
  input  logic [3:0]    i_dir_btn,
  output logic          o_map_rd_en,
  output logic [AW-1:0] o_map_addr,
  input  logic [2:0]    i_map_rdata,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic [1:0]    o_dir,
  output logic          o_moving,
  output logic          o_busy,
  output logic          o_overrun
);

  localparam int TS = $clog2(TILE);
  localparam int CW = XW - TS;
  localparam int RW = YW - TS;

  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_R = 2'd2;
  localparam logic [1:0] DIR_L = 2'd3;

  localparam logic [XW-1:0] X_MAX   = XW'(MAP_COLS * TILE - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(MAP_ROWS * TILE - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(MAP_COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(MAP_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PROBE_A = 3'd1,
    S_CHECK_A = 3'd2,
    S_PROBE_B = 3'd3,
    S_CHECK_B = 3'd4
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [1:0]    r_dir;
  logic [1:0]    r_pend_dir;
  logic          r_pend_vld;
  logic [1:0]    r_probe_dir;
  logic          r_moving;
  logic          r_busy;
  logic          r_overrun;
  logic          r_map_rd_en;
  logic [AW-1:0] r_map_addr;

  logic          w_aligned;
  logic          w_reverse;
  logic          w_wall;
  logic          w_btn_any;
  logic [1:0]    w_btn_dir;

  function automatic logic [XW-1:0] f_step_x(input logic [XW-1:0] x, input logic [1:0] d);
    logic [XW-1:0] nx;
    case (d)
      DIR_R:   nx = (x == X_MAX) ? {XW{1'b0}} : x + XW'(1);
      DIR_L:   nx = (x == {XW{1'b0}}) ? X_MAX : x - XW'(1);
      default: nx = x;
    endcase
    return nx;
  endfunction

  function automatic logic [YW-1:0] f_step_y(input logic [YW-1:0] y, input logic [1:0] d);
    logic [YW-1:0] ny;
    case (d)
      DIR_D:   ny = (y == Y_MAX) ? {YW{1'b0}} : y + YW'(1);
      DIR_U:   ny = (y == {YW{1'b0}}) ? Y_MAX : y - YW'(1);
      default: ny = y;
    endcase
    return ny;
  endfunction

  // Map address of the tile adjacent to the actor's tile in direction d, wrapping at the edges.
  function automatic logic [AW-1:0] f_nb_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                               input logic [1:0] d);
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [31:0]   lin;
    col = x[XW-1:TS];
    row = y[YW-1:TS];
    case (d)
      DIR_U:   row = (row == {RW{1'b0}}) ? ROW_MAX : row - RW'(1);
      DIR_D:   row = (row == ROW_MAX) ? {RW{1'b0}} : row + RW'(1);
      DIR_R:   col = (col == COL_MAX) ? {CW{1'b0}} : col + CW'(1);
      default: col = (col == {CW{1'b0}}) ? COL_MAX : col - CW'(1);
    endcase
    lin = 32'(row) * 32'(MAP_COLS) + 32'(col);
    return lin[AW-1:0];
  endfunction

  assign w_aligned = (r_x[TS-1:0] == {TS{1'b0}}) && (r_y[TS-1:0] == {TS{1'b0}});
  assign w_reverse = r_pend_vld && (r_pend_dir == (r_dir ^ 2'd1));
  assign w_wall    = |i_map_rdata;
  assign w_btn_any = |i_dir_btn;

  // Highest-priority pressed direction, U over D over R over L.
  always_comb begin
    w_btn_dir = DIR_L;
    if (i_dir_btn[3]) begin
      w_btn_dir = DIR_U;
    end else if (i_dir_btn[2]) begin
      w_btn_dir = DIR_D;
    end else if (i_dir_btn[1]) begin
      w_btn_dir = DIR_R;
    end else begin
      w_btn_dir = DIR_L;
    end
  end

  // Movement FSM, pending-turn buffer and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= XW'(START_X);
      r_y         <= YW'(START_Y);
      r_dir       <= START_DIR;
      r_pend_dir  <= DIR_U;
      r_pend_vld  <= 1'b0;
      r_probe_dir <= DIR_U;
      r_moving    <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_map_rd_en <= 1'b0;
      r_map_addr  <= {AW{1'b0}};
    end else begin
      r_overrun <= i_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_tick) begin
            if (w_reverse) begin
              r_dir      <= r_pend_dir;
              r_pend_vld <= 1'b0;
              r_x        <= f_step_x(r_x, r_pend_dir);
              r_y        <= f_step_y(r_y, r_pend_dir);
              r_moving   <= 1'b1;
            end else if (!w_aligned) begin
              r_x      <= f_step_x(r_x, r_dir);
              r_y      <= f_step_y(r_y, r_dir);
              r_moving <= 1'b1;
            end else if (r_pend_vld) begin
              r_probe_dir <= r_pend_dir;
              r_state     <= S_PROBE_A;
              r_busy      <= 1'b1;
            end else begin
              r_state <= S_PROBE_B;
              r_busy  <= 1'b1;
            end
          end
        end
        // A probe state spends one cycle raising the read strobe, then hands over to its check.
        S_PROBE_A: begin
          if (!r_map_rd_en) begin
            r_map_rd_en <= 1'b1;
            r_map_addr  <= f_nb_addr(r_x, r_y, r_probe_dir);
          end else begin
            r_map_rd_en <= 1'b0;
            r_state     <= S_CHECK_A;
          end
        end
        S_CHECK_A: begin
          if (!w_wall) begin
            r_dir <= r_probe_dir;
            if (r_pend_dir == r_probe_dir) begin
              r_pend_vld <= 1'b0;
            end
            r_x      <= f_step_x(r_x, r_probe_dir);
            r_y      <= f_step_y(r_y, r_probe_dir);
            r_moving <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_map_rd_en <= 1'b1;
            r_map_addr  <= f_nb_addr(r_x, r_y, r_dir);
            r_state     <= S_PROBE_B;
          end
        end
        S_PROBE_B: begin
          if (!r_map_rd_en) begin
            r_map_rd_en <= 1'b1;
            r_map_addr  <= f_nb_addr(r_x, r_y, r_dir);
          end else begin
            r_map_rd_en <= 1'b0;
            r_state     <= S_CHECK_B;
          end
        end
        S_CHECK_B: begin
          if (!w_wall) begin
            r_x      <= f_step_x(r_x, r_dir);
            r_y      <= f_step_y(r_y, r_dir);
            r_moving <= 1'b1;
          end else begin
            r_moving <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_map_rd_en <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
      // A fresh button press outranks the clear of an honoured request in the same cycle.
      if (w_btn_any) begin
        r_pend_dir <= w_btn_dir;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign o_map_rd_en = r_map_rd_en;
  assign o_map_addr  = r_map_addr;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_dir       = r_dir;
  assign o_moving    = r_moving;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

endmodule
